// File: rtl/spi_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_arb_pkg
// Shared types and helpers for the SPI write arbiter.
//   arb_state_e : arbiter sequencing states
//   DW_DEFAULT  : default byte width, matches the writer's write_data port
//   MAX_NREQ    : widest requester vector the round-robin helper supports
//   rr_pick()   : round-robin grant index for a request vector and last grant
// -----------------------------------------------------------------------------
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int DW_DEFAULT = 8;
    localparam int MAX_NREQ   = 8;

    // Rotate so the search starts just after 'last', take the first set bit,
    // and map back to an absolute index. Candidates are walked from farthest to
    // nearest so the nearest set bit overwrites any earlier match. With no bit
    // set the result is 'last' and the caller ignores it.
    function automatic logic [2:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                           input logic [2:0]          last,
                                           input int                  nreq);
        logic [2:0] pick;
        logic [2:0] idx;
        pick = last;
        for (int k = MAX_NREQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = 3'((int'(last) + k) % nreq);
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_write_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector (rotate / priority-encode /
// unrotate). Holds no state; the last-grant pointer lives in the top level.
//   req     : request vector, one bit per requester
//   last    : index of the previously granted requester
//   gnt_idx : index of the requester to grant next
//   gnt_any : at least one request is pending
// -----------------------------------------------------------------------------
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    gnt_any
);

    localparam int IW = $clog2(NREQ);

    logic [2:0] pick;

    // The package helper works on the widest vector; narrow its result back
    // to this instance's index width by matching each legal value.
    always_comb begin
        pick    = rr_pick(MAX_NREQ'(req), 3'(last), NREQ);
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == 3'(i)) begin
                gnt_idx = IW'(i);
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/spi_write_arbiter.sv
// -----------------------------------------------------------------------------
// spi_write_arbiter
// Round-robin arbiter that shares one SPI byte writer between NREQ requesters.
// One byte is tracked from grant through the writer's busy period, so only a
// single write is ever in flight. A watchdog returns to IDLE if the writer
// stalls.
//   CLK, RST     : clock, asynchronous active-high reset
//   req_valid    : per-requester request, held until accepted
//   req_data     : requester i's byte at [i*DW +: DW]
//   req_ready    : one-hot single-cycle accept pulse
//   wr_en        : writer EN_write, only ever high while wr_rdy is high
//   wr_data      : writer write_data, registered at grant
//   wr_rdy       : writer RDY_write
//   grant_id     : index of the current or last granted requester
//   busy         : high in every state except IDLE
//   err_timeout  : sticky watchdog flag
//   err_clear    : single-cycle clear of err_timeout
// -----------------------------------------------------------------------------
module spi_write_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int DW             = DW_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    wr_en,
    output logic [DW-1:0]           wr_data,
    input  logic                    wr_rdy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_timeout,
    input  logic                    err_clear
);

    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e     state_q, state_d;
    logic [DW-1:0]  wr_data_q, wr_data_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  grant_id_q, grant_id_d;
    logic           err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [IW-1:0]  gnt_idx;
    logic           gnt_any;
    logic           grant;
    logic           timeout_hit;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req     (req_valid),
        .last    (last_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Next-state logic. req_ready and wr_en are decoded from the registered
    // state so the accept pulse coincides with the grant cycle and wr_en can
    // follow wr_rdy without a cycle of lag. The grant is gated by RST so no
    // accept pulse can escape while reset is held.
    always_comb begin
        state_d     = state_q;
        wr_data_d   = wr_data_q;
        last_d      = last_q;
        grant_id_d  = grant_id_q;
        err_d       = err_q;
        wd_d        = wd_q;
        req_ready   = '0;
        wr_en       = 1'b0;

        grant       = !RST && (state_q == IDLE) && wr_rdy && gnt_any;
        // The watchdog fires on the cycle whose increment would reach the limit.
        timeout_hit = (state_q != IDLE) && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

        if (state_q != IDLE) begin
            wd_d = wd_q + WDW'(1);
        end

        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready[gnt_idx] = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt_idx == IW'(i)) begin
                            wr_data_d = req_data[i*DW +: DW];
                        end
                    end
                    last_d     = gnt_idx;
                    grant_id_d = gnt_idx;
                    wd_d       = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wr_en = wr_rdy;
                if (wr_rdy) begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Ready still high right after the write means the writer
                // finished with zero latency.
                state_d = wr_rdy ? IDLE : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (wr_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The abandoned byte is dropped; its requester was already acked.
        if (timeout_hit) begin
            wr_en   = 1'b0;
            state_d = IDLE;
        end

        // A new timeout outranks a simultaneous clear.
        if (err_clear) begin
            err_d = 1'b0;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    // All arbiter state. Reset points 'last' at the final requester so that
    // requester 0 is first in line after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            wr_data_q  <= '0;
            last_q     <= IW'(NREQ - 1);
            grant_id_q <= '0;
            err_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_data_q  <= wr_data_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
        end
    end

    assign wr_data     = wr_data_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_write_arbiter
// Self-checking bench for spi_write_arbiter with a behavioural SPI writer
// model. Expected grants and bytes are queued when requests are driven and
// matched against the grants and writes observed on the DUT ports.
// -----------------------------------------------------------------------------
module tb_spi_write_arbiter;

    localparam int NREQ        = 4;
    localparam int DW          = 8;
    localparam int TIMEOUT     = 64;
    localparam int BUSY_CYCLES = 21;

    logic                    CLK;
    logic                    RST;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*DW-1:0]      req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    wr_en;
    logic [DW-1:0]           wr_data;
    logic                    wr_rdy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    busy;
    logic                    err_timeout;
    logic                    err_clear;

    int tests_run    = 0;
    int tests_failed = 0;

    // Writer model mode: 0 = normal busy period, 1 = zero latency, 2 = manual.
    int writer_mode = 2;
    int busy_left   = 0;
    int wen_count   = 0;
    int cyc         = 0;

    int            grant_q[$];
    logic [DW-1:0] obs_data_q[$];
    int            en_cyc_q[$];
    int            exp_id_q[$];
    logic [DW-1:0] exp_data_q[$];

    spi_write_arbiter #(
        .NREQ           (NREQ),
        .DW             (DW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_rdy      (wr_rdy),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clear   (err_clear)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor plus writer model: sample at the falling edge, react just after
    // the rising edge. In normal mode an accepted byte drops ready for
    // BUSY_CYCLES cycles.
    initial begin : monitor_writer
        bit en_seen;
        forever begin
            @(negedge CLK);
            en_seen = (wr_en === 1'b1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] === 1'b1) grant_q.push_back(i);
            end
            if (en_seen) begin
                obs_data_q.push_back(wr_data);
                en_cyc_q.push_back(cyc);
                wen_count++;
            end
            @(posedge CLK);
            cyc++;
            #1;
            case (writer_mode)
                0: begin
                    if (en_seen) begin
                        wr_rdy    = 1'b0;
                        busy_left = BUSY_CYCLES;
                    end else if (busy_left > 0) begin
                        busy_left--;
                        if (busy_left == 0) wr_rdy = 1'b1;
                    end
                end
                1: wr_rdy = 1'b1;
                default: ;
            endcase
        end
    end

    initial begin : global_guard
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, now %0t", $time);
        $fatal(1);
    end

    task automatic apply_reset();
        @(posedge CLK); #1;
        writer_mode = 2;
        RST         = 1'b1;
        req_valid   = '0;
        err_clear   = 1'b0;
        wr_rdy      = 1'b1;
        busy_left   = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        grant_q.delete(); obs_data_q.delete(); en_cyc_q.delete();
        exp_id_q.delete(); exp_data_q.delete();
        wen_count = 0;
    endtask

    task automatic load_table_bytes();
        req_data = {8'h54, 8'h3F, 8'h2A, 8'h15};
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        int n;
        n = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge CLK);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        apply_reset();
        @(posedge CLK); #1;
        RST = 1'b1; req_valid = '1; wr_rdy = 1'b1; load_table_bytes();
        #1;
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wr_en: got %b want 0", wr_en); end
        tests_run++; if (req_ready !== '0) begin tests_failed++; $display("[TB] FAIL rst_req_ready: got %b want 0000", req_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        tests_run++; if (wr_data !== '0) begin tests_failed++; $display("[TB] FAIL rst_wr_data: got %h want 00", wr_data); end
        tests_run++; if (grant_id !== '0) begin tests_failed++; $display("[TB] FAIL rst_grant_id: got %0d want 0", grant_id); end
        tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_err: got %b want 0", err_timeout); end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL rst_first_grant: got %b want 0001", req_ready); end
        @(posedge CLK); #1;
        req_valid = '0;
    endtask

    task automatic test_single();
        int n; bit ok; int e_id, o_id; logic [DW-1:0] e_d, o_d;
        $display("[TB] test_single");
        apply_reset();
        writer_mode = 0;
        req_data = '0;
        req_data[2*DW +: DW] = 8'hAA;
        req_valid = 4'b0100;
        exp_id_q.push_back(2); exp_data_q.push_back(8'hAA);
        @(negedge CLK);
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL single_ready: got %b want 0100", req_ready); end
        @(posedge CLK); #1;
        req_valid = '0;
        @(negedge CLK);
        tests_run++; if (wr_en !== 1'b1 || wr_data !== 8'hAA) begin tests_failed++; $display("[TB] FAIL single_write: got en=%b data=%h want en=1 data=aa", wr_en, wr_data); end
        @(negedge CLK);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_en_pulse: got %b want 0", wr_en); end
        n = 1;
        while (busy === 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        // IDLE returns two cycles after the writer's busy period ends.
        tests_run++; if (n != BUSY_CYCLES + 2) begin tests_failed++; $display("[TB] FAIL single_done: busy low after %0d cycles want %0d", n, BUSY_CYCLES + 2); end
        ok = 1'b1;
        while (exp_id_q.size() > 0) begin
            e_id = exp_id_q.pop_front(); e_d = exp_data_q.pop_front();
            tests_run++;
            if (grant_q.size() == 0 || obs_data_q.size() == 0) begin
                tests_failed++; $display("[TB] FAIL single_sb: missing transfer, want id %0d data %h", e_id, e_d);
            end else begin
                o_id = grant_q.pop_front(); o_d = obs_data_q.pop_front();
                if (o_id != e_id || o_d !== e_d) begin tests_failed++; $display("[TB] FAIL single_sb: got id %0d data %h want id %0d data %h", o_id, o_d, e_id, e_d); end
            end
        end
        if (!ok) ;
    endtask

    task automatic test_round_robin();
        int n; bit ok; int e_id, o_id; logic [DW-1:0] e_d, o_d;
        logic [DW-1:0] bytes [NREQ];
        $display("[TB] test_round_robin");
        bytes = '{8'h15, 8'h2A, 8'h3F, 8'h54};
        apply_reset();
        writer_mode = 0;
        load_table_bytes();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            exp_id_q.push_back(k % NREQ);
            exp_data_q.push_back(bytes[k % NREQ]);
        end
        n = 0;
        while (grant_q.size() < 5 && n < 5 * 30) begin
            @(negedge CLK);
            n++;
        end
        tests_run++; if (grant_q.size() < 5) begin tests_failed++; $display("[TB] FAIL rr_grants: got %0d grants want 5", grant_q.size()); end
        @(posedge CLK); #1;
        req_valid = '0;
        wait_idle(60, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL rr_idle: busy=%b want 0", busy); end
        for (int k = 1; k < en_cyc_q.size(); k++) begin
            tests_run++;
            if (en_cyc_q[k] - en_cyc_q[k-1] != BUSY_CYCLES + 3) begin
                tests_failed++; $display("[TB] FAIL rr_spacing: writes %0d apart want %0d", en_cyc_q[k] - en_cyc_q[k-1], BUSY_CYCLES + 3);
            end
        end
        while (exp_id_q.size() > 0) begin
            e_id = exp_id_q.pop_front(); e_d = exp_data_q.pop_front();
            tests_run++;
            if (grant_q.size() == 0 || obs_data_q.size() == 0) begin
                tests_failed++; $display("[TB] FAIL rr_sb: missing transfer, want id %0d data %h", e_id, e_d);
            end else begin
                o_id = grant_q.pop_front(); o_d = obs_data_q.pop_front();
                if (o_id != e_id || o_d !== e_d) begin tests_failed++; $display("[TB] FAIL rr_sb: got id %0d data %h want id %0d data %h", o_id, o_d, e_id, e_d); end
            end
        end
    endtask

    task automatic test_not_ready();
        int stray; bit ok; int e_id, o_id; logic [DW-1:0] e_d, o_d;
        $display("[TB] test_not_ready");
        apply_reset();
        wr_rdy = 1'b0;
        req_data = '0;
        req_data[1*DW +: DW] = 8'h5C;
        req_valid = 4'b0010;
        exp_id_q.push_back(1); exp_data_q.push_back(8'h5C);
        stray = 0;
        repeat (6) begin
            @(negedge CLK);
            if (req_ready !== '0 || wr_en !== 1'b0 || busy !== 1'b0) stray++;
        end
        tests_run++; if (stray != 0) begin tests_failed++; $display("[TB] FAIL notready_hold: %0d active cycles want 0", stray); end
        @(posedge CLK); #1;
        wr_rdy = 1'b1;
        @(negedge CLK);
        tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("[TB] FAIL notready_grant: got %b want 0010", req_ready); end
        @(posedge CLK); #1;
        req_valid = '0;
        @(negedge CLK);
        tests_run++; if (wr_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL notready_wr_en: got %b want 1", wr_en); end
        @(posedge CLK); #1;
        wr_rdy = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        wr_rdy = 1'b1;
        wait_idle(10, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL notready_idle: busy=%b want 0", busy); end
        while (exp_id_q.size() > 0) begin
            e_id = exp_id_q.pop_front(); e_d = exp_data_q.pop_front();
            tests_run++;
            if (grant_q.size() == 0 || obs_data_q.size() == 0) begin
                tests_failed++; $display("[TB] FAIL notready_sb: missing transfer, want id %0d data %h", e_id, e_d);
            end else begin
                o_id = grant_q.pop_front(); o_d = obs_data_q.pop_front();
                if (o_id != e_id || o_d !== e_d) begin tests_failed++; $display("[TB] FAIL notready_sb: got id %0d data %h want id %0d data %h", o_id, o_d, e_id, e_d); end
            end
        end
    endtask

    task automatic test_watchdog();
        int early;
        $display("[TB] test_watchdog");
        apply_reset();
        load_table_bytes();
        req_valid = 4'b1000;
        @(negedge CLK);
        tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("[TB] FAIL wd_grant: got %b want 1000", req_ready); end
        @(posedge CLK); #1;
        req_valid = '0; wr_rdy = 1'b0;
        early = 0;
        // ISSUE is entered at the grant edge; the flag lands TIMEOUT edges later.
        repeat (TIMEOUT) begin
            @(negedge CLK);
            if (err_timeout !== 1'b0 || busy !== 1'b1) early++;
        end
        tests_run++; if (early != 0) begin tests_failed++; $display("[TB] FAIL wd_early: %0d cycles off before limit want 0", early); end
        @(negedge CLK);
        tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("[TB] FAIL wd_set: got %b want 1", err_timeout); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL wd_idle: busy=%b want 0", busy); end
        tests_run++; if (wen_count != 0) begin tests_failed++; $display("[TB] FAIL wd_no_wr_en: %0d writes want 0", wen_count); end
        repeat (2) @(negedge CLK);
        tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("[TB] FAIL wd_sticky: got %b want 1", err_timeout); end
        @(posedge CLK); #1;
        err_clear = 1'b1;
        @(posedge CLK); #1;
        err_clear = 1'b0;
        @(negedge CLK);
        tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL wd_clear: got %b want 0", err_timeout); end
        // Second stall with err_clear raised on the very cycle the watchdog fires.
        @(posedge CLK); #1;
        wr_rdy = 1'b1; req_valid = 4'b1000;
        @(negedge CLK);
        @(posedge CLK); #1;
        req_valid = '0; wr_rdy = 1'b0;
        repeat (TIMEOUT - 1) @(posedge CLK);
        #1;
        err_clear = 1'b1;
        @(posedge CLK); #1;
        err_clear = 1'b0;
        @(negedge CLK);
        tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("[TB] FAIL wd_set_wins: got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_mid();
        int n, base_wen; bit ok; int e_id, o_id; logic [DW-1:0] e_d, o_d;
        $display("[TB] test_reset_mid");
        apply_reset();
        writer_mode = 0;
        load_table_bytes();
        req_valid = 4'b0010;
        exp_id_q.push_back(1); exp_data_q.push_back(8'h2A);
        @(negedge CLK);
        @(posedge CLK); #1;
        req_valid = '0;
        repeat (5) @(posedge CLK);
        #1;
        tests_run++; if (busy !== 1'b1 || wr_rdy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_in_flight: busy=%b rdy=%b want 1 0", busy, wr_rdy); end
        req_valid = '1;
        RST = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0 || wr_en !== 1'b0 || req_ready !== '0) begin tests_failed++; $display("[TB] FAIL mid_rst_ctrl: busy=%b en=%b ready=%b want 0 0 0000", busy, wr_en, req_ready); end
        tests_run++; if (wr_data !== '0 || grant_id !== '0 || err_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_regs: data=%h id=%0d err=%b want 00 0 0", wr_data, grant_id, err_timeout); end
        base_wen = wen_count;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_id_q.push_back(0); exp_data_q.push_back(8'h15);
        n = 0;
        while (grant_q.size() < 2 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        tests_run++; if (grant_q.size() < 2) begin tests_failed++; $display("[TB] FAIL mid_regrant: got %0d grants want 2", grant_q.size()); end
        @(posedge CLK); #1;
        req_valid = '0;
        wait_idle(60, ok);
        tests_run++; if (!ok || wen_count != base_wen + 1) begin tests_failed++; $display("[TB] FAIL mid_no_stray: %0d writes after reset want 1", wen_count - base_wen); end
        while (exp_id_q.size() > 0) begin
            e_id = exp_id_q.pop_front(); e_d = exp_data_q.pop_front();
            tests_run++;
            if (grant_q.size() == 0 || obs_data_q.size() == 0) begin
                tests_failed++; $display("[TB] FAIL mid_sb: missing transfer, want id %0d data %h", e_id, e_d);
            end else begin
                o_id = grant_q.pop_front(); o_d = obs_data_q.pop_front();
                if (o_id != e_id || o_d !== e_d) begin tests_failed++; $display("[TB] FAIL mid_sb: got id %0d data %h want id %0d data %h", o_id, o_d, e_id, e_d); end
            end
        end
    endtask

    task automatic test_zero_latency();
        int n; bit ok; int e_id, o_id; logic [DW-1:0] e_d, o_d;
        $display("[TB] test_zero_latency");
        apply_reset();
        writer_mode = 1;
        load_table_bytes();
        req_valid = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            exp_id_q.push_back((k % 2 == 0) ? 2 : 3);
            exp_data_q.push_back((k % 2 == 0) ? 8'h3F : 8'h54);
        end
        n = 0;
        while (grant_q.size() < 4 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        tests_run++; if (grant_q.size() < 4) begin tests_failed++; $display("[TB] FAIL zl_grants: got %0d grants want 4", grant_q.size()); end
        @(posedge CLK); #1;
        req_valid = '0;
        wait_idle(10, ok);
        tests_run++; if (!ok || err_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL zl_idle: busy=%b err=%b want 0 0", busy, err_timeout); end
        for (int k = 1; k < en_cyc_q.size(); k++) begin
            tests_run++;
            if (en_cyc_q[k] - en_cyc_q[k-1] != 3) begin
                tests_failed++; $display("[TB] FAIL zl_spacing: writes %0d apart want 3", en_cyc_q[k] - en_cyc_q[k-1]);
            end
        end
        while (exp_id_q.size() > 0) begin
            e_id = exp_id_q.pop_front(); e_d = exp_data_q.pop_front();
            tests_run++;
            if (grant_q.size() == 0 || obs_data_q.size() == 0) begin
                tests_failed++; $display("[TB] FAIL zl_sb: missing transfer, want id %0d data %h", e_id, e_d);
            end else begin
                o_id = grant_q.pop_front(); o_d = obs_data_q.pop_front();
                if (o_id != e_id || o_d !== e_d) begin tests_failed++; $display("[TB] FAIL zl_sb: got id %0d data %h want id %0d data %h", o_id, o_d, e_id, e_d); end
            end
        end
    endtask

    initial begin : main
        RST       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        wr_rdy    = 1'b1;
        err_clear = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_not_ready();
        test_watchdog();
        test_reset_mid();
        test_zero_latency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
